// File: rtl/sram_1r1w_if.sv
// Request/response bundle for the sram_1r1w write and read ports.
// master issues writes and read requests; slave (the memory) returns read data.
interface sram_1r1w_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wbe;
    logic                    re;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;

    modport master (output we, waddr, wdata, wbe, re, raddr, input rdata, rvalid);
    modport slave  (input we, waddr, wdata, wbe, re, raddr, output rdata, rvalid);
endinterface

// File: rtl/sram_1r1w.sv
// One-write/one-read register-file memory with byte enables, 1- or 2-cycle read
// latency and selectable same-address read-during-write behaviour.
module sram_1r1w #(
    parameter int SIZE         = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    sram_1r1w_if.slave bus
);
    localparam int NBYTES = DATA_WIDTH / 8;

    // Byte-lane merge shared by the write path and the write-through read path.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;

    // Address range decode and the word captured at the request edge.
    always_comb begin
        w_wr_ok   = bus.we && (32'(bus.waddr) < SIZE);
        w_rd_ok   = (32'(bus.raddr) < SIZE);
        w_collide = w_wr_ok && (bus.waddr == bus.raddr);
        w_rd_word = {DATA_WIDTH{1'b0}};
        if (w_rd_ok) begin
            if ((RDW_MODE == 1) && w_collide) begin
                w_rd_word = merge_bytes(r_mem[bus.raddr], bus.wdata, bus.wbe);
            end else begin
                w_rd_word = r_mem[bus.raddr];
            end
        end else begin
            w_rd_word = {DATA_WIDTH{1'b0}};
        end
    end

    // Latency select: bypass the middle stage when READ_LATENCY is 1.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_data  = {DATA_WIDTH{1'b0}};
        if (READ_LATENCY == 2) begin
            w_out_valid = r_s1_valid;
            w_out_data  = r_s1_data;
        end else begin
            w_out_valid = bus.re;
            w_out_data  = w_rd_word;
        end
    end

    // Storage array: cleared on reset, byte-masked writes otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_mem[bus.waddr] <= merge_bytes(r_mem[bus.waddr], bus.wdata, bus.wbe);
        end
    end

    // Read pipeline; rdata only moves on a valid result so it holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DATA_WIDTH{1'b0}};
            r_rvalid   <= 1'b0;
            r_rdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_s1_valid <= bus.re;
            if (bus.re) begin
                r_s1_data <= w_rd_word;
            end
            r_rvalid <= w_out_valid;
            if (w_out_valid) begin
                r_rdata <= w_out_data;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
endmodule

// File: tb/tb_sram_1r1w.sv
// Bench for sram_1r1w: three configurations share one stimulus stream; a reference
// model feeds a scoreboard queue, and the first instance is also held to hand-derived vectors.
module tb_sram_1r1w;
    localparam int NDUT = 3;
    localparam int SZ  [NDUT] = '{16, 16, 12};
    localparam int LAT [NDUT] = '{1, 1, 2};
    localparam int RDW [NDUT] = '{0, 1, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t_we, t_re;
    logic [3:0]  t_waddr, t_raddr, t_wbe;
    logic [31:0] t_wdata;

    always #5 clk = ~clk;

    sram_1r1w_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b0 ();
    sram_1r1w_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b1 ();
    sram_1r1w_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) b2 ();

    assign b0.we = t_we; assign b0.waddr = t_waddr; assign b0.wdata = t_wdata;
    assign b0.wbe = t_wbe; assign b0.re = t_re; assign b0.raddr = t_raddr;
    assign b1.we = t_we; assign b1.waddr = t_waddr; assign b1.wdata = t_wdata;
    assign b1.wbe = t_wbe; assign b1.re = t_re; assign b1.raddr = t_raddr;
    assign b2.we = t_we; assign b2.waddr = t_waddr; assign b2.wdata = t_wdata;
    assign b2.wbe = t_wbe; assign b2.re = t_re; assign b2.raddr = t_raddr;

    sram_1r1w #(.SIZE(16), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    sram_1r1w #(.SIZE(16), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    sram_1r1w #(.SIZE(12), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic [31:0] rd [NDUT];
    logic        rv [NDUT];
    assign rd[0] = b0.rdata; assign rv[0] = b0.rvalid;
    assign rd[1] = b1.rdata; assign rv[1] = b1.rvalid;
    assign rd[2] = b2.rdata; assign rv[2] = b2.rvalid;

    typedef struct {
        int          dut;
        int          due;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] exp0;
    } vec_t;

    localparam int NTAB = 15;
    vec_t        tab [NTAB];
    sb_t         sbq [$];
    logic [31:0] m    [NDUT][16];
    logic [31:0] last [NDUT];
    int          cyc, n_chk, n_err;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (n & mask) | (o & ~mask);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour at one rising edge; reads see the pre-write model state.
    task automatic model_edge(input bit use_tab, input logic [31:0] exp0);
        logic [31:0] v;
        if (!rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                last[k] = 32'h0;
                for (int a = 0; a < 16; a++) m[k][a] = 32'h0;
            end
            sbq.delete();
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (t_re) begin
                    v = 32'h0;
                    if (int'(t_raddr) < SZ[k]) begin
                        v = m[k][t_raddr];
                        if (RDW[k] == 1 && t_we && t_waddr == t_raddr) v = mrg(v, t_wdata, t_wbe);
                    end
                    if (k == 0 && use_tab) v = exp0;
                    sbq.push_back('{k, cyc + LAT[k] - 1, v});
                end
                if (t_we && int'(t_waddr) < SZ[k]) m[k][t_waddr] = mrg(m[k][t_waddr], t_wdata, t_wbe);
            end
        end
    endtask

    task automatic check_outputs();
        int          idx;
        logic        ev;
        logic [31:0] ed;
        for (int k = 0; k < NDUT; k++) begin
            idx = -1;
            for (int i = 0; i < sbq.size(); i++) begin
                if (sbq[i].dut == k) begin
                    idx = i;
                    break;
                end
            end
            if (idx >= 0 && sbq[idx].due == cyc) begin
                ev = 1'b1;
                ed = sbq[idx].data;
                sbq.delete(idx);
                last[k] = ed;
            end else begin
                ev = 1'b0;
                ed = last[k];
            end
            chk($sformatf("rvalid_u%0d", k), {31'b0, rv[k]}, {31'b0, ev});
            chk($sformatf("rdata_u%0d", k), rd[k], ed);
        end
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic re, input logic [3:0] ra,
                        input bit use_tab, input logic [31:0] exp0);
        t_we = we; t_waddr = wa; t_wdata = wd; t_wbe = be; t_re = re; t_raddr = ra;
        @(posedge clk);
        cyc++;
        model_edge(use_tab, exp0);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, a, d, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic rdq(input logic [3:0] a);
        step(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a, 1'b0, 32'h0);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0;
        t_we = 1'b0; t_re = 1'b0; t_waddr = 4'h0; t_raddr = 4'h0; t_wbe = 4'h0; t_wdata = 32'h0;

        // Expected values below are for instance u0 (read-old, latency 1, 16 words).
        tab[0]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  32'h0000_0000};
        tab[1]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 1'b0, 4'd0,  32'h0};
        tab[2]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 1'b0, 4'd0,  32'h0};
        tab[3]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'hAA22CC44};
        tab[4]  = '{1'b1, 4'd7,  32'h12345678, 4'hF, 1'b0, 4'd0,  32'h0};
        tab[5]  = '{1'b1, 4'd7,  32'hFFFFFFFF, 4'h3, 1'b1, 4'd7,  32'h12345678};
        tab[6]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  32'h1234FFFF};
        tab[7]  = '{1'b1, 4'd13, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  32'h0};
        tab[8]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd13, 32'hDEADBEEF};
        tab[9]  = '{1'b1, 4'd9,  32'hCAFEF00D, 4'h0, 1'b1, 4'd9,  32'h0000_0000};
        tab[10] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd9,  32'h0000_0000};
        tab[11] = '{1'b1, 4'd2,  32'h000000A5, 4'h1, 1'b1, 4'd3,  32'hAA22CC44};
        tab[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd2,  32'h000000A5};
        tab[13] = '{1'b1, 4'd15, 32'h00000055, 4'hF, 1'b1, 4'd14, 32'h0000_0000};
        tab[14] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  32'h0};

        // Reset with both ports requesting: neither may take effect.
        step(1'b1, 4'd3, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd3, 1'b0, 32'h0);
        step(1'b1, 4'd4, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd4, 1'b0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NTAB; i++) begin
            step(tab[i].we, tab[i].wa, tab[i].wd, tab[i].be, tab[i].re, tab[i].ra, 1'b1, tab[i].exp0);
        end
        idle();

        // Back-to-back reads through the 2-cycle pipeline.
        wr(4'd0, 32'h10); wr(4'd1, 32'h11); wr(4'd2, 32'h12);
        rdq(4'd0); rdq(4'd1); rdq(4'd2);
        idle(); idle(); idle();

        // Writes landing while an earlier read is still in flight.
        rdq(4'd0);
        step(1'b1, 4'd0, 32'h99, 4'hF, 1'b1, 4'd0, 1'b0, 32'h0);
        wr(4'd0, 32'h77);
        idle(); idle(); idle();

        // Reset arriving behind a read request, then read everything back.
        wr(4'd1, 32'h55);
        rdq(4'd1);
        rst_n = 1'b0;
        step(1'b1, 4'd1, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd1, 1'b0, 32'h0);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) rdq(4'(a));
        idle(); idle();

        // Mixed random traffic with frequent same-address collisions.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] wa, ra;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ra, 1'b0, 32'h0);
        end
        idle(); idle(); idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_1r1w.md
SRAM_1R1W -- requirements
Module: sram_1r1w

Interface
REQ-001 Parameter SIZE, default 16, number of words.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits; it SHALL be a multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 4, address width; ADDR_WIDTH SHALL be >= $clog2(SIZE).
REQ-004 Parameter READ_LATENCY, default 1, legal values 1 or 2: cycles from read request to data.
REQ-005 Parameter RDW_MODE, default 0, same-address read-during-write behaviour: 0 = read-old, 1 = write-through.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  ADDR_WIDTH  write address.
REQ-010 wdata  input  DATA_WIDTH  write data.
REQ-011 wbe  input  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 re  input  1  read enable.
REQ-013 raddr  input  ADDR_WIDTH  read address.
REQ-014 rdata  output  DATA_WIDTH  read data.
REQ-015 rvalid  output  1  rdata carries the result of a read this cycle.

Function
REQ-016 Read and write ports SHALL be independent; a read and a write in the same cycle SHALL both be performed (no read priority, no dropped write).
REQ-017 Write: at a rising edge with rst_n=1, we=1 and waddr<SIZE, each byte of mem[waddr] with wbe bit set SHALL take the wdata byte; bytes with wbe bit clear SHALL be unchanged.
REQ-018 we=1 with wbe all zero SHALL leave memory unchanged.
REQ-019 Writes with waddr>=SIZE SHALL be discarded without side effects.
REQ-020 Read: a request sampled at edge N (re=1) SHALL present rdata with rvalid=1 during the cycle after edge N+READ_LATENCY-1, i.e. 1 cycle later for READ_LATENCY=1 and 2 cycles later for READ_LATENCY=2.
REQ-021 The read pipeline SHALL accept one request per cycle; back-to-back reads SHALL produce back-to-back rvalid pulses in request order.
REQ-022 rvalid SHALL be 0 in every cycle without a matching request; rdata SHALL hold its last value while rvalid=0.
REQ-023 Reads with raddr>=SIZE SHALL return all-zero data with rvalid=1.
REQ-024 Same-cycle read and write to the same in-range address, RDW_MODE=0: read SHALL return the pre-write word.
REQ-025 Same case, RDW_MODE=1: read SHALL return the merged word (new bytes where wbe=1, old bytes elsewhere).
REQ-026 A read issued the cycle after a write to the same address SHALL return the written data in both modes.
REQ-027 With READ_LATENCY=2, a write landing between request and data SHALL NOT alter the returned data; data is the value captured at the request edge per REQ-024/025.

Reset
REQ-028 At a rising edge with rst_n=0, all SIZE words SHALL become zero, rdata SHALL become 0, rvalid SHALL become 0 and all in-flight read requests SHALL be discarded.
REQ-029 Reset SHALL override we and re in the same cycle; neither SHALL take effect.
REQ-030 After rst_n returns to 1, the first edge SHALL accept reads and writes normally; a read at that edge SHALL return 0 for any address not yet written.

Verification
REQ-031 Reset, then read addr 5 (READ_LATENCY=1) -> next cycle rvalid=1, rdata=0x00000000.
REQ-032 Write 0xAABBCCDD to addr 3 with wbe=4'b1111, then write 0x11223344 with wbe=4'b0101, then read addr 3 -> rdata=0xAA22CC44.
REQ-033 Addr 7 holds 0x12345678; same cycle write 0xFFFFFFFF, wbe=4'b0011, and read addr 7 -> RDW_MODE=0 returns 0x12345678, RDW_MODE=1 returns 0x1234FFFF; a read the following cycle returns 0x1234FFFF in both.
REQ-034 READ_LATENCY=2, reads addr 0,1,2 on consecutive cycles (holding 0x10,0x11,0x12) -> rvalid high 2-4 cycles after the first request, rdata 0x10,0x11,0x12 in order.
REQ-035 SIZE=12, ADDR_WIDTH=4: write 0xDEADBEEF to addr 13, then read addr 13 -> rdata=0, rvalid=1; no in-range word changed.
REQ-036 READ_LATENCY=2, read issued, rst_n=0 on the next edge -> rvalid stays 0, rdata=0, all words read back 0 after reset.
